// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the default prefetch depth, reset vector and the {pc, instr} entry layout.
package fetch_unit_pkg;

  localparam int unsigned FETCH_DEPTH  = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Modular 32-bit increment; the top word wraps to zero.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with single-cycle flush.
// The head entry is read straight from storage so the outputs carry no extra logic.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_wdata,
  output fetch_entry_t             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_full    = (r_count == DEPTH_C);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  // Next occupancy; flush dominates any push or pop.
  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = {CW{1'b0}};
    end else if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      r_count <= w_count_nxt;
      if (i_flush) begin
        r_wr_ptr <= {PW{1'b0}};
        r_rd_ptr <= {PW{1'b0}};
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Entry storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch address, captures the combinational code word
// into the prefetch FIFO and arbitrates push, pop and redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            code_addr,
  input  logic [31:0]            r_code,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr_data,
  output logic [31:0]            instr_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_fetch_pc_nxt;
  logic         w_push;
  logic         w_pop;
  logic         w_empty;
  logic         w_full;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_head;

  assign code_addr   = r_fetch_pc;
  assign instr_valid = !w_empty;
  assign instr_data  = w_head.instr;
  assign instr_pc    = w_head.pc;

  // Redirect discards both sides of the handshake in its cycle.
  assign w_pop      = !w_empty && instr_ready && !redirect;
  assign w_push     = fetch_en && !redirect && (!w_full || w_pop);
  assign w_wr_entry = '{pc: r_fetch_pc, instr: r_code};

  // Next fetch address: redirect target, sequential advance, or hold.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect) begin
      w_fetch_pc_nxt = word_align(redirect_pc);
    end else if (w_push) begin
      w_fetch_pc_nxt = next_word(r_fetch_pc);
    end else begin
      w_fetch_pc_nxt = r_fetch_pc;
    end
  end

  // Fetch address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= word_align(RESET_PC);
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_wdata (w_wr_entry),
    .o_rdata (w_head),
    .o_count (fifo_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference queue of {pc, instr} entries is filled
// as fetches are accepted and compared against the FIFO head as decode consumes it.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] code_addr;
  logic [31:0] r_code;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  fifo_count;

  logic        w_en;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_addr;
  logic [31:0] w_code;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [31:0] w_pc;
  logic [2:0]  w_cnt;

  logic [31:0] m_pc;
  logic [63:0] q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd8) return 32'hE1A010A2;
    else return {a[15:0], 16'hC0DE} ^ {16'h0000, a[31:16]};
  endfunction

  assign r_code = mem_word(code_addr);
  assign w_code = mem_word(w_addr);

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .code_addr(code_addr), .r_code(r_code),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .fifo_count(fifo_count)
  );

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(w_en), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .code_addr(w_addr), .r_code(w_code),
    .instr_valid(w_valid), .instr_ready(w_ready), .instr_data(w_data),
    .instr_pc(w_pc), .fifo_count(w_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, advance the model by one cycle, then clock.
  task automatic step();
    logic        do_pop;
    logic        do_push;
    logic [63:0] e;
    check_eq("code_addr", code_addr, m_pc);
    check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
    check_eq("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      check_eq("head_pc", instr_pc, e[63:32]);
      check_eq("head_data", instr_data, e[31:0]);
    end
    do_pop  = (q.size() != 0) && instr_ready && !redirect;
    do_push = fetch_en && !redirect && ((q.size() < DEPTH) || do_pop);
    if (redirect) begin
      q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (do_pop) e = q.pop_front();
      if (do_push) begin
        q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    m_pc = 32'h0000_0000;
    @(posedge clk);
    #1;
    check_eq("rst_code_addr", code_addr, 32'h0000_0000);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;
  endtask

  initial begin
    fetch_en = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    w_en = 1'b1; w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    #2;

    // Streaming from reset, plus address wrap on the second instance.
    do_reset();
    step();
    check_eq("seq_pc0", instr_pc, 32'h0);
    check_eq("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    step();
    check_eq("seq_pc4", instr_pc, 32'h4);
    check_eq("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    step();
    check_eq("seq_pc8", instr_pc, 32'h8);
    check_eq("seq_data8", instr_data, 32'hE1A010A2);
    check_eq("wrap_pc2", w_pc, 32'h0);
    check_eq("wrap_valid", 32'(w_valid), 32'd1);
    repeat (3) step();

    // Fill with decode stalled, then drain with no bubble.
    do_reset();
    instr_ready = 1'b0;
    repeat (4) step();
    check_eq("full_count", 32'(fifo_count), 32'd4);
    repeat (2) step();
    check_eq("full_hold_addr", code_addr, 32'd16);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("drain_valid", 32'(instr_valid), 32'd1);
      check_eq("drain_pc", instr_pc, 32'(4 * i));
      step();
    end

    // Redirect to an unaligned target while full.
    instr_ready = 1'b0;
    repeat (4) step();
    check_eq("pre_redir_count", 32'(fifo_count), 32'd4);
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    step();
    redirect = 1'b0;
    check_eq("redir_count", 32'(fifo_count), 32'd0);
    check_eq("redir_valid", 32'(instr_valid), 32'd0);
    check_eq("redir_addr", code_addr, 32'h40);
    step();
    check_eq("redir_target_pc", instr_pc, 32'h40);

    // Redirect colliding with a handshake, then a back-to-back redirect.
    step(); step();
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    check_eq("b2b_addr", code_addr, 32'h200);
    check_eq("b2b_count", 32'(fifo_count), 32'd0);
    step();
    check_eq("b2b_count1", 32'(fifo_count), 32'd1);
    check_eq("b2b_pc", instr_pc, 32'h200);
    repeat (3) step();

    // Fetch disabled: address freezes while the FIFO drains.
    fetch_en = 1'b0;
    repeat (4) step();
    fetch_en = 1'b1;
    repeat (2) step();

    // Asynchronous reset between edges mid-burst.
    instr_ready = 1'b0;
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_code_addr", code_addr, 32'h0);
    check_eq("async_count", 32'(fifo_count), 32'd0);
    check_eq("async_valid", 32'(instr_valid), 32'd0);
    check_eq("async_wrap_addr", w_addr, 32'hFFFF_FFF8);
    q.delete();
    m_pc = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the unified memory block's code read port. Drives the word-aligned code address, captures the 32-bit instruction word returned combinationally on the same cycle, and buffers it in a small prefetch FIFO. Decode consumes instructions from the FIFO through a valid/ready handshake. A single-cycle redirect flushes the buffer and restarts fetch at a new target.

## Interface
- `DEPTH`, 4: prefetch FIFO entries, power of two, minimum 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset, byte offset into the code region.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `fetch_en` input 1: fetch enable; 0 freezes fetching, FIFO still drains.
- `redirect` input 1: branch/exception redirect strobe.
- `redirect_pc` input 32: new fetch address; bits [1:0] ignored and forced to 0.
- `code_addr` output 32: byte address to memory code port, always word-aligned.
- `r_code` input 32: instruction word from memory, valid combinationally for current `code_addr`.
- `instr_valid` output 1: FIFO head holds an instruction.
- `instr_ready` input 1: decode accepts the head this cycle.
- `instr_data` output 32: head instruction word.
- `instr_pc` output 32: address the head instruction was fetched from.
- `fifo_count` output $clog2(DEPTH)+1: occupied entries, for debug and bench.

## Operation
- The block keeps the registered `fetch_pc` and drives `code_addr = fetch_pc` directly.
- Pop: `instr_valid && instr_ready && !redirect`.
- Push: `fetch_en && !redirect && (count < DEPTH || pop)`. On a push, write {`fetch_pc`, `r_code`} at the tail and set `fetch_pc <= fetch_pc + 4`, using 32-bit modular wrap (32'hFFFF_FFFC wraps to 0).
- Without a push, `fetch_pc` holds. The address stays stable while the FIFO is full or `fetch_en` is 0.
- Redirect has priority over everything else:
  - count is set to 0 and the read/write pointers reset.
  - Any pop or push in that cycle is discarded.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
- Back-to-back redirects: the last one wins. Each redirect flushes again.
- Push and pop in the same cycle leave count unchanged. When full, a push is legal only together with a pop.
- `instr_data`/`instr_pc` are the head entry and are valid only while `instr_valid` is 1. When empty they keep stale values and must not be checked.
- FIFO storage has no reset requirement. Pointers, count and `fetch_pc` are reset.

## Timing
- Reset values:
  - `fetch_pc`/`code_addr` = `RESET_PC` with bits [1:0] cleared.
  - count = 0, `instr_valid` = 0, `fifo_count` = 0.
  - `instr_data`/`instr_pc` are don't-care.
- Reset assertion mid-operation: all of the above take effect immediately (asynchronous) and any in-flight FIFO contents are lost. Release is synchronous to the next `clk` edge.
- Fetch latency: a word presented at `code_addr` in cycle N appears at the head with `instr_valid` = 1 in cycle N+1 if the FIFO was empty.
- Redirect latency: redirect in cycle N gives `instr_valid` = 0 in N+1, `code_addr` = target in N+1, and the target instruction valid in N+2.
- Throughput: one instruction per cycle sustained while `instr_ready` = 1 and `fetch_en` = 1.
- No combinational path from `instr_ready` or `redirect` to `code_addr`. Outputs are registered or taken directly from FIFO storage.

## Structure
- Shared defines header gains `FETCH_DEPTH` and `RESET_VECTOR`. The existing code-region base constant stays owned by memory; this block emits offsets only.
- One natural sub-module: `fetch_fifo`, a parameterised synchronous FIFO with flush, storing 64-bit {pc, instr} entries, with `push`/`pop`/`flush`/`count`.
- The top level holds `fetch_pc` and the push/pop/redirect arbitration.

## Test plan
- Reset, `fetch_en` = 1, `instr_ready` = 1, memory word at offset 8 = 32'hE1A010A2: `instr_pc` sequence 0, 4, 8 on consecutive cycles starting 1 cycle after reset release; `instr_data` at pc 8 is E1A010A2.
- `instr_ready` held 0 with DEPTH = 4: `fifo_count` reaches 4 after 4 cycles, then `code_addr` holds at 16. Raising ready yields pcs 0, 4, 8, 12, 16 with no gap.
- Redirect to 32'h0000_0043 while full:
  - Next cycle `fifo_count` = 0, `instr_valid` = 0, `code_addr` = 32'h40.
  - The cycle after, `instr_pc` = 32'h40.
- Redirect in the same cycle as a ready handshake: the head is not consumed, the FIFO is flushed, and there is no duplicate or lost count.
- `RESET_PC` = 32'hFFFF_FFF8: fetches FFF8, FFFC, then 0.
- Assert `rst_n` mid-burst between clock edges: outputs go to reset values immediately, before the next edge.
